cdce62005_spi_responder: RTL and testbench

CDCE62005_SPI_RESPONDER -- requirements
Module: cdce62005_spi_responder

---
 rtl/cdce62005_spi_responder_pkg.sv | 19 +
 rtl/cdce62005_spi_responder_if.sv | 12 +
 rtl/cdce62005_spi_responder_sync.sv | 32 +++
 rtl/cdce62005_spi_responder.sv | 216 +++++++++++++++++++++
 tb/tb_cdce62005_spi_responder.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cdce62005_spi_responder_pkg.sv
// Shared constants and types for the CDCE62005 SPI register responder.
// The optional EEPROM shadow bank is enabled with the CDCE_EEPROM_EN macro.
package cdce_spi_pkg;

    localparam int          FRAME_LEN  = 32;
    localparam int          NUM_REGS   = 9;
    localparam logic [3:0]  CMD_READ   = 4'hE;
    localparam logic [31:0] CMD_EEPROM = 32'h1F;
    localparam logic [3:0]  EE_ADDR    = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        RX,
        DECODE
    } state_t;

    typedef logic [27:0] reg_word_t;

endpackage

// File: rtl/cdce62005_spi_responder_if.sv
// SPI wire bundle between a CDCE62005-style master and the register responder.
interface cdce62005_spi_responder_if;

    logic spi_clk;
    logic spi_le;
    logic spi_mosi;
    logic spi_miso;

    modport master (output spi_clk, spi_le, spi_mosi, input spi_miso);
    modport slave  (input spi_clk, spi_le, spi_mosi, output spi_miso);

endinterface

// File: rtl/cdce62005_spi_responder_sync.sv
// Two-flop synchronizer for one SPI input plus single-cycle rise/fall pulses.
module spi_edge_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic s1, s2, s3;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= RST_VAL;
            s2 <= RST_VAL;
            s3 <= RST_VAL;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign dout = s2;
    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

endmodule

// File: rtl/cdce62005_spi_responder.sv
// CDCE62005-style SPI register responder: 32-bit LSB-first frames, 9-word bank, readback.
// Define CDCE_EEPROM_EN to add the EEPROM shadow bank and its copy/readback commands.
module cdce62005_spi_responder
    import cdce_spi_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spi_clk,
    input  logic        spi_le,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        word_valid,
    output logic [3:0]  word_addr,
    output logic [27:0] word_data,
    output logic        frame_err,
    output logic        cmd_err,
    input  logic [3:0]  bank_rd_addr,
    output logic [27:0] bank_rd_data
);

    logic sclk_s_unused, sclk_rise, sclk_fall;
    logic le_s_unused, le_rise, le_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_edge_sync #(.RST_VAL(1'b0)) u_sync_clk (
        .clk(clk), .rst_n(rst_n), .din(spi_clk),
        .dout(sclk_s_unused), .rise(sclk_rise), .fall(sclk_fall));

    // The latch-enable line idles high, so its synchronizer resets high to avoid a false frame start.
    spi_edge_sync #(.RST_VAL(1'b1)) u_sync_le (
        .clk(clk), .rst_n(rst_n), .din(spi_le),
        .dout(le_s_unused), .rise(le_rise), .fall(le_fall));

    spi_edge_sync #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .din(spi_mosi),
        .dout(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused));

    state_t      state, state_nxt;
    logic [5:0]  bit_cnt;
    logic [31:0] rx_word;
    reg_word_t   bank [NUM_REGS];
    logic [3:0]  rd_ptr;
    logic        rd_pending;
    logic        tx_active;
    logic [31:0] tx_shift;
    logic [31:0] tx_load;
    logic        wv_pend;

    logic frame_start, frame_end, clk_take;
    logic dec_write, dec_read, dec_eeprom, dec_bad;
    logic [3:0] nib;

`ifdef CDCE_EEPROM_EN
    reg_word_t  shadow [NUM_REGS];
    logic [3:0] ee_idx;
`endif

    assign nib = rx_word[3:0];

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_nxt   = state;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        clk_take    = 1'b0;
        dec_write   = 1'b0;
        dec_read    = 1'b0;
        dec_eeprom  = 1'b0;
        dec_bad     = 1'b0;
        case (state)
            IDLE: begin
                if (le_fall) begin
                    frame_start = 1'b1;
                    state_nxt   = RX;
                end
            end
            RX: begin
                // A clock edge coinciding with the frame end belongs to no bit.
                clk_take = sclk_rise & ~le_rise;
                if (le_rise) begin
                    frame_end = 1'b1;
                    state_nxt = (bit_cnt == 6'(FRAME_LEN)) ? DECODE : IDLE;
                end
            end
            DECODE: begin
                state_nxt = IDLE;
                if (nib < 4'(NUM_REGS))
                    dec_write = 1'b1;
                else if (nib == CMD_READ)
                    dec_read = 1'b1;
`ifdef CDCE_EEPROM_EN
                else if (rx_word == CMD_EEPROM)
                    dec_eeprom = 1'b1;
`endif
                else
                    dec_bad = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            rx_word <= '0;
        end else begin
            state <= state_nxt;
            if (frame_start) begin
                bit_cnt <= '0;
                rx_word <= '0;
            end else if (clk_take) begin
                if (bit_cnt < 6'(FRAME_LEN))
                    rx_word[bit_cnt[4:0]] <= mosi_s;
                if (bit_cnt < 6'(FRAME_LEN + 1))
                    bit_cnt <= bit_cnt + 6'd1;
            end
        end
    end

    // NOTE: the bank is reset explicitly because its contents are architecturally visible on readback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) bank[i] <= '0;
        end else if (dec_write) begin
            bank[nib] <= rx_word[31:4];
        end
    end

`ifdef CDCE_EEPROM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
        end else if (dec_eeprom) begin
            for (int i = 0; i < NUM_REGS; i++) shadow[i] <= bank[i];
        end
    end
`endif

    // Commit pulse trails the bank write by one cycle; address and data are already stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wv_pend    <= 1'b0;
            word_valid <= 1'b0;
            word_addr  <= '0;
            word_data  <= '0;
            frame_err  <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            wv_pend    <= dec_write;
            word_valid <= wv_pend;
            frame_err  <= frame_end && (bit_cnt != 6'(FRAME_LEN));
            cmd_err    <= dec_bad;
            if (dec_write) begin
                word_addr <= nib;
                word_data <= rx_word[31:4];
            end
        end
    end

    always_comb begin
        tx_load = {28'd0, rd_ptr};
        if (rd_ptr < 4'(NUM_REGS))
            tx_load = {bank[rd_ptr], rd_ptr};
`ifdef CDCE_EEPROM_EN
        else if (rd_ptr == EE_ADDR)
            tx_load = {shadow[ee_idx], ee_idx};
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            rd_pending <= 1'b0;
`ifdef CDCE_EEPROM_EN
            ee_idx     <= '0;
`endif
        end else if (dec_read) begin
            rd_ptr     <= rx_word[7:4];
            rd_pending <= 1'b1;
`ifdef CDCE_EEPROM_EN
            ee_idx     <= '0;
`endif
        end else if (frame_end && tx_active) begin
`ifdef CDCE_EEPROM_EN
            // Shadow readback stays armed until all nine words have gone out.
            if (rd_ptr == EE_ADDR && ee_idx != 4'(NUM_REGS - 1)) begin
                ee_idx <= ee_idx + 4'd1;
            end else begin
                rd_pending <= 1'b0;
                ee_idx     <= '0;
            end
`else
            rd_pending <= 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_active <= 1'b0;
            tx_shift  <= '0;
        end else if (frame_start && rd_pending) begin
            tx_active <= 1'b1;
            tx_shift  <= tx_load;
        end else if (frame_end) begin
            tx_active <= 1'b0;
        end else if (state == RX && tx_active && sclk_fall) begin
            tx_shift <= {1'b0, tx_shift[31:1]};
        end
    end

    assign spi_miso     = tx_active & tx_shift[0];
    assign bank_rd_data = (bank_rd_addr < 4'(NUM_REGS)) ? bank[bank_rd_addr] : '0;

endmodule

// File: tb/tb_cdce62005_spi_responder.sv
// Directed bench for cdce62005_spi_responder: vector table of write/command frames plus
// hand sequences for readback, short/long frames, mid-frame reset and the EEPROM copy.
module tb_cdce62005_spi_responder;

    localparam int HALF = 50;

    logic        clk;
    logic        rst_n;
    logic        word_valid;
    logic [3:0]  word_addr;
    logic [27:0] word_data;
    logic        frame_err;
    logic        cmd_err;
    logic [3:0]  bank_rd_addr;
    logic [27:0] bank_rd_data;

    cdce62005_spi_responder_if spi ();

    cdce62005_spi_responder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .spi_clk      (spi.spi_clk),
        .spi_le       (spi.spi_le),
        .spi_mosi     (spi.spi_mosi),
        .spi_miso     (spi.spi_miso),
        .word_valid   (word_valid),
        .word_addr    (word_addr),
        .word_data    (word_data),
        .frame_err    (frame_err),
        .cmd_err      (cmd_err),
        .bank_rd_addr (bank_rd_addr),
        .bank_rd_data (bank_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int          wv_cnt = 0, fe_cnt = 0, ce_cnt = 0;
    logic [3:0]  last_addr = '0;
    logic [27:0] last_data = '0;
    int          base_wv, base_fe, base_ce;

    always @(negedge clk) begin
        if (word_valid) begin
            wv_cnt    <= wv_cnt + 1;
            last_addr <= word_addr;
            last_data <= word_data;
        end
        if (frame_err) fe_cnt <= fe_cnt + 1;
        if (cmd_err)   ce_cnt <= ce_cnt + 1;
    end

    typedef struct {
        logic [31:0] frame;
        logic        exp_valid;
        logic        exp_cmd_err;
        logic [3:0]  exp_addr;
        logic [27:0] exp_data;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic snap();
        @(negedge clk);
        base_wv = wv_cnt;
        base_fe = fe_cnt;
        base_ce = ce_cnt;
    endtask

    task automatic send_frame(input logic [31:0] w, input int nclk, output logic [31:0] miso_word);
        miso_word = '0;
        @(negedge clk);
        spi.spi_le = 1'b0;
        #(2 * HALF);
        for (int i = 0; i < nclk; i++) begin
            spi.spi_mosi = (i < 32) ? w[i] : 1'b0;
            #HALF;
            if (i < 32) miso_word[i] = spi.spi_miso;
            spi.spi_clk = 1'b1;
            #HALF;
            spi.spi_clk = 1'b0;
        end
        #HALF;
        spi.spi_le   = 1'b1;
        spi.spi_mosi = 1'b0;
        #(4 * HALF);
    endtask

    task automatic rd_bank(input logic [3:0] a, output logic [27:0] d);
        @(negedge clk);
        bank_rd_addr = a;
        @(negedge clk);
        d = bank_rd_data;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n        = 1'b0;
        spi.spi_clk  = 1'b0;
        spi.spi_le   = 1'b1;
        spi.spi_mosi = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        logic [31:0] m;
        logic [27:0] d;

        vecs[0] = '{32'h81400320, 1'b1, 1'b0, 4'd0, 28'h8140032};
        vecs[1] = '{32'h12345679, 1'b0, 1'b1, 4'd0, 28'h0};
        vecs[2] = '{32'h04BE09E6, 1'b1, 1'b0, 4'd6, 28'h04BE09E};
        vecs[3] = '{32'h80001808, 1'b1, 1'b0, 4'd8, 28'h8000180};
        vecs[4] = '{32'h0000002F, 1'b0, 1'b1, 4'd0, 28'h0};
        vecs[5] = '{32'hA5A5A5AB, 1'b0, 1'b1, 4'd0, 28'h0};
        vecs[6] = '{32'h68860323, 1'b1, 1'b0, 4'd3, 28'h6886032};
        vecs[7] = '{32'hFFFFFFF2, 1'b1, 1'b0, 4'd2, 28'hFFFFFFF};

        rst_n        = 1'b0;
        spi.spi_clk  = 1'b0;
        spi.spi_le   = 1'b1;
        spi.spi_mosi = 1'b0;
        bank_rd_addr = '0;
        repeat (5) @(negedge clk);

        check("rst_miso",       32'(spi.spi_miso), 32'h0);
        check("rst_word_valid", 32'(word_valid),   32'h0);
        check("rst_word_addr",  32'(word_addr),    32'h0);
        check("rst_word_data",  32'(word_data),    32'h0);
        check("rst_frame_err",  32'(frame_err),    32'h0);
        check("rst_cmd_err",    32'(cmd_err),      32'h0);
        check("rst_bank0",      32'(bank_rd_data), 32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Vector table
        for (int v = 0; v < 8; v++) begin
            snap();
            send_frame(vecs[v].frame, 32, m);
            check($sformatf("vec%0d_valid_cnt", v), 32'(wv_cnt - base_wv), vecs[v].exp_valid ? 32'd1 : 32'd0);
            check($sformatf("vec%0d_cmd_err_cnt", v), 32'(ce_cnt - base_ce), vecs[v].exp_cmd_err ? 32'd1 : 32'd0);
            check($sformatf("vec%0d_frame_err_cnt", v), 32'(fe_cnt - base_fe), 32'd0);
            check($sformatf("vec%0d_miso_idle", v), m, 32'h0);
            if (vecs[v].exp_valid) begin
                check($sformatf("vec%0d_addr", v), 32'(last_addr), 32'(vecs[v].exp_addr));
                check($sformatf("vec%0d_data", v), 32'(last_data), 32'(vecs[v].exp_data));
                rd_bank(vecs[v].exp_addr, d);
                check($sformatf("vec%0d_bank", v), 32'(d), 32'(vecs[v].exp_data));
            end
        end
        rd_bank(4'd9, d);
        check("bank_addr9_zero", 32'(d), 32'h0);
        rd_bank(4'd15, d);
        check("bank_addr15_zero", 32'(d), 32'h0);

        // Readback of register 3 through a dummy frame
        do_reset();
        send_frame(32'h68860323, 32, m);
        snap();
        send_frame(32'h0000003E, 32, m);
        check("rdcmd_no_valid", 32'(wv_cnt - base_wv), 32'd0);
        check("rdcmd_no_cmd_err", 32'(ce_cnt - base_ce), 32'd0);
        send_frame(32'h00000000, 32, m);
        check("readback_word", m, 32'h68860323);
        rd_bank(4'd0, d);
        check("readback_bank0", 32'(d), 32'h0);
        rd_bank(4'd3, d);
        check("readback_bank3", 32'(d), 32'h6886032);
        send_frame(32'h00000001, 32, m);
        check("readback_cleared", m, 32'h0);

        // Short frame then good frame
        snap();
        send_frame(32'h04BE09E6, 31, m);
        check("short_frame_err", 32'(fe_cnt - base_fe), 32'd1);
        check("short_no_valid", 32'(wv_cnt - base_wv), 32'd0);
        rd_bank(4'd6, d);
        check("short_bank6", 32'(d), 32'h0);
        snap();
        send_frame(32'h04BE09E6, 32, m);
        check("after_short_frame_err", 32'(fe_cnt - base_fe), 32'd0);
        rd_bank(4'd6, d);
        check("after_short_bank6", 32'(d), 32'h04BE09E);

        // Long frame
        snap();
        send_frame(32'h11111115, 33, m);
        check("long_frame_err", 32'(fe_cnt - base_fe), 32'd1);
        check("long_no_valid", 32'(wv_cnt - base_wv), 32'd0);
        rd_bank(4'd5, d);
        check("long_bank5", 32'(d), 32'h0);

        // Reset in the middle of a frame
        snap();
        @(negedge clk);
        spi.spi_le = 1'b0;
        #(2 * HALF);
        for (int i = 0; i < 16; i++) begin
            spi.spi_mosi = logic'((32'h80001808 >> i) & 32'h1);
            #HALF;
            spi.spi_clk = 1'b1;
            #HALF;
            spi.spi_clk = 1'b0;
        end
        do_reset();
        #(4 * HALF);
        check("midrst_no_valid", 32'(wv_cnt - base_wv), 32'd0);
        check("midrst_no_frame_err", 32'(fe_cnt - base_fe), 32'd0);
        check("midrst_no_cmd_err", 32'(ce_cnt - base_ce), 32'd0);
        rd_bank(4'd8, d);
        check("midrst_bank8", 32'(d), 32'h0);
        snap();
        send_frame(32'h80001808, 32, m);
        check("postrst_valid", 32'(wv_cnt - base_wv), 32'd1);
        check("postrst_frame_err", 32'(fe_cnt - base_fe), 32'd0);
        rd_bank(4'd8, d);
        check("postrst_bank8", 32'(d), 32'h8000180);

        // EEPROM copy
        for (int i = 0; i < 9; i++)
            send_frame({28'h0A0B0C0 + 28'(i), 4'(i)}, 32, m);
        snap();
        send_frame(32'h0000001F, 32, m);
`ifdef CDCE_EEPROM_EN
        check("eeprom_no_cmd_err", 32'(ce_cnt - base_ce), 32'd0);
        send_frame(32'h000000FE, 32, m);
        for (int i = 0; i < 9; i++) begin
            send_frame(32'h0000000C, 32, m);
            check($sformatf("shadow%0d", i), m, {28'h0A0B0C0 + 28'(i), 4'(i)});
        end
        send_frame(32'h0000000C, 32, m);
        check("shadow_done", m, 32'h0);
`else
        check("eeprom_cmd_err", 32'(ce_cnt - base_ce), 32'd1);
        check("eeprom_no_valid", 32'(wv_cnt - base_wv), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
